// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART TX serializer
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]         tx_data_o,
  output logic                      tx_start_o,
  input  logic                      tx_busy_i,
  input  logic                      tx_done_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      timeout_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ACCEPT, START, WAIT} state_t;
  state_t        state;
  logic [IW-1:0] last_winner, owner, pick, k;
  logic [CW-1:0] cnt;
  logic          last_q, xfer;
  assign req_ready_o = (state == ACCEPT) ? (req_valid_i & grant_o) : '0;
  assign xfer        = |req_ready_o;
  assign tx_start_o  = (state == START) && !tx_busy_i;
  // Offset 1 from the last winner is visited last, so it has the highest priority.
  always_comb begin
    pick = last_winner;
    k = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = IW'((int'(last_winner) + i) % NUM_REQ);
      pick = req_valid_i[k] ? k : pick;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_winner <= IW'(NUM_REQ - 1);
      owner       <= '0;
      grant_o     <= '0;
      cnt         <= '0;
      last_q      <= 1'b0;
      tx_data_o   <= '0;
      timeout_o   <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: if (|req_valid_i) begin
          owner   <= pick;
          grant_o <= NUM_REQ'(1) << pick;
          cnt     <= '0;
          state   <= ACCEPT;
        end
        ACCEPT: if (xfer) begin
          tx_data_o <= req_data_i[owner*DATA_W +: DATA_W];
          last_q    <= req_last_i[owner];
          cnt       <= '0;
          state     <= START;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          timeout_o   <= 1'b1;
          grant_o     <= '0;
          last_winner <= owner;
          state       <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        START: if (!tx_busy_i) state <= WAIT;
        WAIT: if (tx_done_i) begin
          if (last_q) begin
            grant_o     <= '0;
            last_winner <= owner;
            state       <= IDLE;
          end else begin
            cnt   <= '0;
            state <= ACCEPT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors and corner-case sequences for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic           clk_i = 1'b0, rst_n = 1'b0;
  logic [N-1:0]   req_valid_i = '0, req_last_i = '0;
  logic [N*W-1:0] req_data_i = '0;
  logic           tx_busy_i = 1'b0, tx_done_i = 1'b0;
  logic [N-1:0]   req_ready_o, grant_o;
  logic [W-1:0]   tx_data_o;
  logic           tx_start_o, timeout_o;
  int n_tests = 0, n_fail = 0;
  logic [3:0] g;
  logic [7:0] d;
  typedef struct {
    logic [3:0] valid;
    logic [3:0] grant;
    logic [7:0] data;
  } vec_t;
  vec_t vecs[12];

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .tx_data_o(tx_data_o),
    .tx_start_o(tx_start_o), .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic setb(input int r, input logic [7:0] v);
    req_data_i[r*W +: W] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  // Waits for a start pulse, captures grant/data, then acknowledges with a done pulse.
  task automatic do_byte(input logic [3:0] clr, output logic [3:0] go, output logic [7:0] dd);
    bit seen;
    seen = 0;
    go = '0;
    dd = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_i);
      if (tx_start_o) seen = 1;
    end
    chk("start_seen", 32'(seen), 1);
    if (seen) begin
      go = grant_o;
      dd = tx_data_o;
      req_valid_i &= ~clr;
      @(negedge clk_i);
      tx_done_i = 1'b1;
      @(negedge clk_i);
      tx_done_i = 1'b0;
    end
  endtask

  always @(negedge clk_i) if (rst_n) begin
    chk("grant_onehot0", 32'($onehot0(grant_o)), 1);
    chk("ready_onehot0", 32'($onehot0(req_ready_o)), 1);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{4'b1111, 4'b0001, 8'h10};
    vecs[1]  = '{4'b1111, 4'b0010, 8'h11};
    vecs[2]  = '{4'b1111, 4'b0100, 8'h12};
    vecs[3]  = '{4'b1111, 4'b1000, 8'h13};
    vecs[4]  = '{4'b1111, 4'b0001, 8'h10};
    vecs[5]  = '{4'b1010, 4'b0010, 8'h11};
    vecs[6]  = '{4'b1010, 4'b1000, 8'h13};
    vecs[7]  = '{4'b0101, 4'b0001, 8'h10};
    vecs[8]  = '{4'b0100, 4'b0100, 8'h12};
    vecs[9]  = '{4'b0011, 4'b0001, 8'h10};
    vecs[10] = '{4'b0011, 4'b0010, 8'h11};
    vecs[11] = '{4'b1000, 4'b1000, 8'h13};
    #1;
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_ready", 32'(req_ready_o), 0);
    chk("rst_start", 32'(tx_start_o), 0);
    chk("rst_data", 32'(tx_data_o), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    do_reset();
    // single byte latency
    setb(1, 8'h5A);
    req_last_i = 4'b1111;
    req_valid_i = 4'b0010;
    @(negedge clk_i);
    chk("sb_grant", 32'(grant_o), 4'b0010);
    chk("sb_ready", 32'(req_ready_o), 4'b0010);
    chk("sb_nostart", 32'(tx_start_o), 0);
    @(negedge clk_i);
    chk("sb_start", 32'(tx_start_o), 1);
    chk("sb_data", 32'(tx_data_o), 8'h5A);
    chk("sb_ready_off", 32'(req_ready_o), 0);
    req_valid_i = '0;
    @(negedge clk_i);
    chk("sb_start_once", 32'(tx_start_o), 0);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    chk("sb_release", 32'(grant_o), 0);
    // round-robin table from a fresh reset
    do_reset();
    for (int r = 0; r < N; r++) setb(r, 8'(8'h10 + r));
    req_last_i = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      req_valid_i = vecs[i].valid;
      do_byte(4'b0000, g, d);
      chk($sformatf("rr%0d_grant", i), 32'(g), 32'(vecs[i].grant));
      chk($sformatf("rr%0d_data", i), 32'(d), 32'(vecs[i].data));
    end
    req_valid_i = '0;
    // packet lock: requester 2 keeps the grant for three bytes while 0 waits
    setb(2, 8'hA0);
    setb(0, 8'h77);
    req_last_i = 4'b0001;
    req_valid_i = 4'b0100;
    @(negedge clk_i);
    chk("lock_grant0", 32'(grant_o), 4'b0100);
    req_valid_i = 4'b0101;
    for (int b = 0; b < 3; b++) begin
      do_byte(4'b0000, g, d);
      chk($sformatf("lock%0d_grant", b), 32'(g), 4'b0100);
      chk($sformatf("lock%0d_data", b), 32'(d), 32'(8'hA0 + b));
      setb(2, 8'(8'hA1 + b));
      req_last_i[2] = (b == 1);
    end
    req_valid_i = 4'b0001;
    do_byte(4'b0001, g, d);
    chk("lock_after_grant", 32'(g), 4'b0001);
    chk("lock_after_data", 32'(d), 8'h77);
    req_valid_i = '0;
    // busy hold
    setb(1, 8'hC3);
    req_last_i = 4'b1111;
    tx_busy_i = 1'b1;
    req_valid_i = 4'b0010;
    @(negedge clk_i);
    chk("busy_grant", 32'(grant_o), 4'b0010);
    @(negedge clk_i);
    req_valid_i = '0;
    for (int i = 0; i < 20; i++) begin
      chk("busy_nostart", 32'(tx_start_o), 0);
      chk("busy_data", 32'(tx_data_o), 8'hC3);
      @(negedge clk_i);
    end
    tx_busy_i = 1'b0;
    #1;
    chk("busy_start", 32'(tx_start_o), 1);
    chk("busy_data_end", 32'(tx_data_o), 8'hC3);
    @(negedge clk_i);
    chk("busy_start_once", 32'(tx_start_o), 0);
    tx_done_i = 1'b1;
    @(negedge clk_i);
    tx_done_i = 1'b0;
    chk("busy_release", 32'(grant_o), 0);
    // timeout on a stalled packet
    setb(3, 8'h33);
    setb(0, 8'h44);
    req_last_i = 4'b0001;
    req_valid_i = 4'b1000;
    do_byte(4'b1000, g, d);
    chk("to_grant", 32'(g), 4'b1000);
    chk("to_data", 32'(d), 8'h33);
    req_valid_i = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      chk("to_quiet", 32'(timeout_o), 0);
      chk("to_locked", 32'(grant_o), 4'b1000);
      @(negedge clk_i);
    end
    chk("to_pulse", 32'(timeout_o), 1);
    chk("to_grant_clr", 32'(grant_o), 0);
    req_valid_i = 4'b1001;
    @(negedge clk_i);
    chk("to_pulse_once", 32'(timeout_o), 0);
    chk("to_next_grant", 32'(grant_o), 4'b0001);
    do_byte(4'b0001, g, d);
    chk("to_next_data", 32'(d), 8'h44);
    req_valid_i = '0;
    // reset while waiting for done
    for (int r = 0; r < N; r++) setb(r, 8'(8'h10 + r));
    req_last_i = 4'b1111;
    req_valid_i = 4'b0100;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk_i);
        if (tx_start_o) seen = 1;
      end
      chk("rw_start_seen", 32'(seen), 1);
    end
    req_valid_i = 4'b1111;
    @(negedge clk_i);
    rst_n = 1'b0;
    #1;
    chk("rw_grant", 32'(grant_o), 0);
    chk("rw_ready", 32'(req_ready_o), 0);
    chk("rw_start", 32'(tx_start_o), 0);
    chk("rw_data", 32'(tx_data_o), 0);
    chk("rw_timeout", 32'(timeout_o), 0);
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    chk("rw_first_grant", 32'(grant_o), 4'b0001);
    chk("rw_no_stale_start", 32'(tx_start_o), 0);
    do_byte(4'b1111, g, d);
    chk("rw_data_after", 32'(d), 8'h10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
